log_8_32: RTL
=============

LOG_8_32 -- requirements
Module: log_8_32

Interface
REQ-001 Parameter: BYTE_W, default 8, width of one input byte.
REQ-002 Parameter: NBYTES, default 4, bytes per assembled word; word width = BYTE_W*NBYTES.
REQ-003 Parameter: HOLD, default 4, clk_4f cycles valid_out stays high after each word completes.
REQ-004 Port: clk_4f  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk_4f.
REQ-006 Port: data_in  input  BYTE_W  byte stream from the 32-to-8 serializer stage.
REQ-007 Port: valid_in  input  1  qualifies data_in in the same cycle.
REQ-008 Port: data_out  output  BYTE_W*NBYTES  last completely assembled word.
REQ-009 Port: valid_out  output  1  data_out holds a fresh word.
REQ-010 Port: err_out  output  1  one-cycle pulse: partial word discarded.

Function
REQ-011 Byte order SHALL be MSB-first: the 1st valid byte of a word lands in data_out[31:24], the 4th in data_out[7:0].
REQ-012 The FSM SHALL have two states: IDLE (byte count 0) and COLLECT (byte count 1..NBYTES-1).
REQ-013 IDLE -> COLLECT on valid_in=1, which stores byte 0 and sets the count to 1.
REQ-014 In COLLECT with valid_in=1: store the byte at the current index and increment the count.
REQ-015 When the NBYTES-th byte is stored: the count wraps to 0 and the FSM returns to IDLE in the same edge.
REQ-016 On completion, the full word SHALL appear on data_out at the next edge; latency from the 4th byte sampled to data_out/valid_out = 1 cycle.
REQ-017 A valid_in=1 in the cycle after completion SHALL start a new word with no bubble; a back-to-back stream yields one word every NBYTES cycles.
REQ-018 valid_out SHALL be high for exactly HOLD cycles after each completion.
REQ-019 A completion during an active hold SHALL reload the hold counter to HOLD, so valid_out stays continuously high for a gapless stream.
REQ-020 data_out SHALL change only on completion; it holds its value when valid_out drops.
REQ-021 valid_in=0 while in COLLECT SHALL:
  - discard the partial word;
  - return the FSM to IDLE with count 0;
  - pulse err_out for one cycle on the next edge.
  It SHALL NOT alter data_out or the running hold counter.
REQ-022 valid_in=0 in IDLE SHALL be a no-op: no error, no state change.
REQ-023 The internal hold counter SHALL be width clog2(HOLD+1) and saturate at 0; no wrap below zero.

Reset
REQ-024 While reset=0 at a rising edge, the block SHALL set:
  - data_out = 0, valid_out = 0, err_out = 0;
  - FSM = IDLE, byte count = 0, hold counter = 0.
REQ-025 Reset mid-word SHALL discard the partial word without an err_out pulse.
REQ-026 The first byte SHALL be accepted on the first edge with reset=1 and valid_in=1.

Structure
REQ-027 The shared defines include SHALL hold BYTE_W, NBYTES, HOLD defaults and the FSM state encodings (IDLE=0, COLLECT=1); the 32-to-8 serializer stage SHALL use the same include.
REQ-028 One sub-module, log_8_32_hold, SHALL implement the reloadable hold counter driving valid_out.
REQ-029 The byte shift/index register and FSM SHALL live in log_8_32.
REQ-030 The block SHALL be synthesizable with the same cell library and flow as the existing stages, producing log_8_32_sint for behavioural vs. structural comparison.

Verification
REQ-031 Reset: hold reset=0 for 2 edges with valid_in=1, data_in=8'hFF -> data_out=0, valid_out=0, err_out=0.
REQ-032 Single word: bytes AA,BB,CC,DD on 4 consecutive edges with valid_in=1 -> next edge data_out=32'hAABBCCDD, valid_out=1 for 4 cycles, then 0; data_out retained.
REQ-033 Stream: 12 gapless bytes 01..0C -> words 01020304, 05060708, 090A0B0C spaced 4 cycles apart; valid_out continuously high until 4 cycles after the last word.
REQ-034 Abort: bytes 11,22, then valid_in=0 for 1 cycle, then 33,44,55,66 -> err_out pulses once; data_out=32'h33445566; 11/22 never appear.
REQ-035 Reset mid-word: bytes 11,22, then reset=0 for 1 edge, then A1..A4 -> no err_out; data_out=32'hA1A2A3A4.
REQ-036 End-to-end: chain log_32_8 -> log_8_32 on clk_4f with words 32'hDEADBEEF, 32'h01234567 -> identical words out; behavioural and synthesized outputs match every cycle.

Source files
------------

// File: rtl/log_8_32_pkg.sv
// Shared defaults and FSM encoding for the byte-to-word assembler and its sibling serializer stage.
package log_8_32_pkg;
  localparam int BYTE_W_DEF = 8;
  localparam int NBYTES_DEF = 4;
  localparam int HOLD_DEF   = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;
endpackage

// File: rtl/log_8_32_hold.sv
// Reloadable down-counter: valid stays high for HOLD cycles after the most recent load.
module log_8_32_hold #(
  parameter int HOLD = 4
) (
  input  logic clk_4f,
  input  logic reset,
  input  logic load,
  output logic valid
);
  localparam int HW = $clog2(HOLD + 1);

  logic [HW-1:0] r_cnt;

  // A reload during an active hold restarts the window, so a gapless stream keeps valid high.
  always_ff @(posedge clk_4f) begin
    if (!reset)               r_cnt <= '0;
    else if (load)            r_cnt <= HW'(HOLD);
    else if (r_cnt != '0)     r_cnt <= r_cnt - 1'b1;
  end

  assign valid = (r_cnt != '0);
endmodule

// File: rtl/log_8_32.sv
// Assembles an MSB-first byte stream into NBYTES-wide words; a gap mid-word aborts it with err_out.
module log_8_32
  import log_8_32_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int NBYTES = NBYTES_DEF,
  parameter int HOLD   = HOLD_DEF
) (
  input  logic                     clk_4f,
  input  logic                     reset,
  input  logic [BYTE_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic [BYTE_W*NBYTES-1:0] data_out,
  output logic                     valid_out,
  output logic                     err_out
);
  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = $clog2(NBYTES);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_shift;
  logic            r_cmp;

  // Shifting left places the first byte of a word in the top lane after NBYTES stores.
  // A discarded partial word needs no clearing: the next word shifts in NBYTES fresh bytes.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_cmp    <= 1'b0;
      data_out <= '0;
      err_out  <= 1'b0;
    end else begin
      r_cmp   <= 1'b0;
      err_out <= 1'b0;
      if (r_cmp) data_out <= r_shift;
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_shift <= {r_shift[W-BYTE_W-1:0], data_in};
            r_cnt   <= CW'(1);
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (valid_in) begin
            r_shift <= {r_shift[W-BYTE_W-1:0], data_in};
            if (r_cnt == CW'(NBYTES - 1)) begin
              r_cnt   <= '0;
              r_state <= IDLE;
              r_cmp   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= IDLE;
            err_out <= 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  log_8_32_hold #(.HOLD(HOLD)) u_hold (
    .clk_4f (clk_4f),
    .reset  (reset),
    .load   (r_cmp),
    .valid  (valid_out)
  );
endmodule
